// File: rtl/dram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_arbiter                                                               |
// | Shares the DRAM master FIFO path between the instruction-side (port 0) and |
// | data-side (port 1) requesters, one line transfer in flight at a time.      |
// | Optional: DRAM_ARB_FIXED_PRIO_EN - port 1 always wins a tie.               |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module dram_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              d_req_valid,
    input  logic              d_req_ready,
    output logic              d_we,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    input  logic              d_rsp_valid,
    input  logic [DATA_W-1:0] d_rdata,
    output logic              busy
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_WAIT_RD = 2'd2;

    logic [1:0] r_state;
    logic       r_owner;
    logic       r_last_grant;
    logic       w_any;
    logic       w_grant;

    always_comb begin
        w_any = m0_req | m1_req;
`ifdef DRAM_ARB_FIXED_PRIO_EN
        // Data side wins whenever it is requesting.
        w_grant = m1_req;
`else
        if (m0_req && m1_req) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = m1_req;
        end
`endif
    end

    assign busy        = (r_state != c_IDLE);
    assign d_req_valid = (r_state == c_ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rvalid    <= 1'b0;
            m1_rvalid    <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            d_we         <= 1'b0;
            d_addr       <= '0;
            d_wdata      <= '0;
        end else begin
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        d_we         <= w_grant ? m1_we    : m0_we;
                        d_addr       <= w_grant ? m1_addr  : m0_addr;
                        d_wdata      <= w_grant ? m1_wdata : m0_wdata;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        m0_ack       <= ~w_grant;
                        m1_ack       <= w_grant;
                        r_state      <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (d_req_ready) begin
                        r_state <= d_we ? c_IDLE : c_WAIT_RD;
                    end
                end
                c_WAIT_RD: begin
                    // Response goes only to the port that issued the read.
                    if (d_rsp_valid) begin
                        if (r_owner) begin
                            m1_rdata  <= d_rdata;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= d_rdata;
                            m0_rvalid <= 1'b1;
                        end
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dram_arbiter                                                            |
// | Directed self-checking bench for dram_arbiter.                             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_dram_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_ack, m0_rvalid, m1_ack, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              d_req_valid, d_req_ready, d_we, d_rsp_valid, busy;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;

    int n_vec = 0;
    int n_err = 0;

    dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the port exp_port to be granted on the next edge; completes
    // its read with resp_delay idle cycles before the response.
    task automatic grant_and_read(input int exp_port, input logic [ADDR_W-1:0] exp_addr,
                                  input logic [DATA_W-1:0] data, input int resp_delay);
        tick();
        check("ack0", m0_ack, (exp_port == 0));
        check("ack1", m1_ack, (exp_port == 1));
        check("rd_valid", d_req_valid, 1'b1);
        check("rd_addr", d_addr, exp_addr);
        check("rd_we", d_we, 1'b0);
        if (exp_port == 0) m0_req = 1'b0; else m1_req = 1'b0;
        d_req_ready = 1'b1;
        tick();
        d_req_ready = 1'b0;
        check("wait_busy", busy, 1'b1);
        check("wait_valid", d_req_valid, 1'b0);
        for (int i = 0; i < resp_delay; i++) tick();
        check("no_early_rv", m0_rvalid | m1_rvalid, 1'b0);
        d_rsp_valid = 1'b1;
        d_rdata     = data;
        tick();
        d_rsp_valid = 1'b0;
        check("rv0", m0_rvalid, (exp_port == 0));
        check("rv1", m1_rvalid, (exp_port == 1));
        check("rdata", (exp_port == 0) ? m0_rdata : m1_rdata, data);
        check("idle_after_rd", busy, 1'b0);
    endtask

    logic [DATA_W-1:0] c_D0 = 128'hDEADBEEF_01234567_89ABCDEF_00112233;
    logic [DATA_W-1:0] c_D1 = 128'hCAFEF00D_11111111_22222222_33333333;
    logic [DATA_W-1:0] c_D2 = 128'h0BADC0DE_44444444_55555555_66666666;
    logic [DATA_W-1:0] c_WD = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

    int first_tie, second_tie;

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        d_req_ready = 0; d_rsp_valid = 0; d_rdata = '0;
        tick(); tick();
        rst = 1'b0;

        check("rst_busy", busy, 1'b0);
        check("rst_dval", d_req_valid, 1'b0);
        check("rst_ack", m0_ack | m1_ack, 1'b0);
        check("rst_addr", d_addr, '0);
        check("rst_rdata0", m0_rdata, '0);

        // Single read on port 0, response 5 cycles after issue.
        m0_req = 1; m0_we = 0; m0_addr = 27'h0000100;
        grant_and_read(0, 27'h0000100, c_D0, 5);
        check("m1_rdata_untouched", m1_rdata, '0);
        tick();
        check("rv_pulse", m0_rvalid, 1'b0);

        // Ties after a fresh reset.
        rst = 1'b1; tick(); rst = 1'b0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
        first_tie = 1; second_tie = 1;
`else
        first_tie = 0; second_tie = 1;
`endif
        m0_req = 1; m0_we = 0; m0_addr = 27'h0000200;
        m1_req = 1; m1_we = 0; m1_addr = 27'h0000300;
        grant_and_read(first_tie, (first_tie == 0) ? 27'h0000200 : 27'h0000300, c_D1, 1);
        // Winner asks again: second tie against the still-waiting port.
        if (first_tie == 0) m0_req = 1; else m1_req = 1;
        grant_and_read(second_tie, (second_tie == 0) ? 27'h0000200 : 27'h0000300, c_D2, 0);
        grant_and_read(0, 27'h0000200, c_D0, 0);

        // Write on port 1 with downstream stalled for 4 cycles.
        m1_req = 1; m1_we = 1; m1_addr = 27'h7FFFFF0; m1_wdata = c_WD;
        tick();
        check("wr_ack1", m1_ack, 1'b1);
        check("wr_we", d_we, 1'b1);
        m1_req = 0; m1_addr = 27'h0000555; m1_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wr_hold_valid", d_req_valid, 1'b1);
            check("wr_hold_addr", d_addr, 27'h7FFFFF0);
            check("wr_hold_data", d_wdata, c_WD);
        end
        d_req_ready = 1;
        tick();
        d_req_ready = 0;
        check("wr_idle", busy, 1'b0);
        check("wr_no_rv", m0_rvalid | m1_rvalid, 1'b0);

        // Spurious response while idle.
        d_rsp_valid = 1; d_rdata = c_D2;
        tick();
        d_rsp_valid = 0;
        tick();
        check("spur_rv", m0_rvalid | m1_rvalid, 1'b0);
        check("spur_idle", busy, 1'b0);
        check("spur_rdata0", m0_rdata, c_D0);

        // Reset while a read waits for its response.
        m0_req = 1; m0_we = 0; m0_addr = 27'h0000400;
        tick();
        m0_req = 0; d_req_ready = 1;
        tick();
        d_req_ready = 0;
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_addr", d_addr, '0);
        check("mid_rst_rdata0", m0_rdata, '0);
        d_rsp_valid = 1; d_rdata = c_D1;
        tick();
        d_rsp_valid = 0;
        tick();
        check("late_rsp_rv", m0_rvalid | m1_rvalid, 1'b0);
        check("late_rsp_rdata0", m0_rdata, '0);
        m1_req = 1; m1_we = 0; m1_addr = 27'h0000600;
        grant_and_read(1, 27'h0000600, c_D2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter that shares the single DRAM master FIFO path (cache side of the clock-crossing buffer in front of the DDR2 controller) between an instruction-side and a data-side requester. Accepts one line-sized read or write request at a time, forwards it downstream, tracks the single outstanding read, and routes its response back to the issuing port. Sits in the CPU clock domain between the caches and the DRAM buffer.

## Interface
- ADDR_W, 27, DRAM byte address width
- DATA_W, 128, line width per transfer
- clk  in  1  CPU clock
- rst  in  1  reset, synchronous, active-high
- m0_req / m1_req  in  1  request pending; hold with fields stable until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  request address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_ack / m1_ack  out  1  one-cycle pulse: request latched, may be dropped
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse: read data valid
- m0_rdata / m1_rdata  out  DATA_W  read data, valid with rvalid
- d_req_valid  out  1  downstream request valid
- d_req_ready  in  1  downstream accepts when valid & ready
- d_we, d_addr, d_wdata  out  1/ADDR_W/DATA_W  latched request fields
- d_rsp_valid  in  1  downstream read response valid (single-cycle)
- d_rdata  in  DATA_W  downstream read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- IDLE: if any mX_req, pick winner, latch we/addr/wdata into d_* regs, record owner, pulse mX_ack, go ISSUE. No request: stay.
- Arbitration: round-robin on last_grant bit; both requesting → grant port != last_grant; one requesting → grant it. last_grant updated on every grant.
- ISSUE: d_req_valid=1, fields stable. On d_req_ready: write → IDLE; read → WAIT_RD.
- WAIT_RD: on d_rsp_valid, register d_rdata to owner's mX_rdata, pulse owner's mX_rvalid next cycle, go IDLE.
- Non-owner rvalid never asserted; mX_rdata of non-owner holds previous value.
- d_rsp_valid in IDLE or ISSUE: ignored, no rvalid.
- mX_req rising while other port owns the path: waits; no ack until IDLE.
- Requester deasserting req before ack: legal, request simply not taken.

## Timing
- Reset values: all acks, rvalids, d_req_valid, busy = 0; d_we=0, d_addr=0, d_wdata=0, mX_rdata=0; state=IDLE; last_grant=1 (port 0 wins first tie); owner=0.
- Request at cycle 0 in IDLE → ack and d_req_valid both high in cycle 1 (registered).
- d_req_ready high in cycle 1 → handshake in cycle 1; write path back in IDLE cycle 2; next grant's ack earliest cycle 3.
- Read: d_rsp_valid in cycle N → mX_rvalid in cycle N+1; IDLE at N+1; next ack earliest N+2.
- rst mid-ISSUE/WAIT_RD: next cycle IDLE with reset values; in-flight request abandoned; late d_rsp_valid ignored.
- At most one downstream transaction outstanding at any time.

## Configuration
- DRAM_ARB_FIXED_PRIO_EN defined: port 1 (data side) always wins ties; last_grant not used for selection (register may remain).
- Undefined (default): round-robin as above.

## Test plan
- Single read port 0, addr 0x0000100, d_req_ready=1, d_rsp_valid 5 cycles later with 0xDEADBEEF_... → m0_ack cycle 1, m0_rvalid one cycle after rsp, m0_rdata matches, m1_rvalid stays 0.
- Simultaneous req both ports (reads), after reset → port 0 granted first, then port 1; swapped order on next tie; with DRAM_ARB_FIXED_PRIO_EN port 1 wins both ties.
- Write port 1 with d_req_ready low 4 cycles → d_req_valid held, d_addr/d_wdata stable, return to IDLE one cycle after handshake, no rvalid.
- Spurious d_rsp_valid in IDLE → no rvalid on either port, state remains IDLE.
- rst asserted in WAIT_RD, then d_rsp_valid → all outputs reset values next cycle, no rvalid, subsequent port 1 read completes normally.
